// File: rtl/diff_layer_seq.sv
// Multi-layer sequencer for the diff core. It queues layer descriptors and launches
// every PE column for each layer, then flips the feature-map bank before the next one.
//
// state  | meaning
// IDLE   | waiting for core_start while a descriptor is queued
// FETCH  | pop the head descriptor into the config registers
// LAUNCH | offer col_valid to every column that has not accepted yet
// RUN    | collect column and write-back finishes; watchdog running
// SWAP   | flip the bank select and count the layer
// WAIT   | a non-last layer is done and the descriptor queue is empty
// DONE   | one-cycle core_finish
// ERR    | watchdog expired; held until abort or rst
module diff_layer_seq #(
    parameter int NUM_COL    = 8,
    parameter int NUM_ROW    = 4,
    parameter int DESC_DEPTH = 4,
    parameter int DIM_W      = 8,
    parameter int TIMEOUT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [DIM_W-1:0]   desc_w_num,
    input  logic [DIM_W-1:0]   desc_h_num,
    input  logic [DIM_W-1:0]   desc_c_num,
    input  logic               desc_bit_mode,
    input  logic               desc_kernel_mode,
    input  logic               desc_last,
    input  logic               core_start,
    input  logic               abort,
    output logic               core_busy,
    output logic               core_finish,
    output logic               core_error,
    output logic [7:0]         layer_cnt,
    output logic [NUM_COL-1:0] col_valid,
    input  logic [NUM_COL-1:0] col_ready,
    input  logic [NUM_COL-1:0] col_finish,
    input  logic [NUM_ROW-1:0] wb_finish,
    output logic [DIM_W-1:0]   w_num,
    output logic [DIM_W-1:0]   h_num,
    output logic [DIM_W-1:0]   c_num,
    output logic               bit_mode,
    output logic               kernel_mode,
    output logic               fm_ping_pong
);
    localparam int AW     = $clog2(DESC_DEPTH);
    localparam int DESC_W = 3 * DIM_W + 3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LAUNCH, S_RUN, S_SWAP, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t              state;
    logic [DESC_W-1:0]   mem [DESC_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push;
    logic [NUM_COL-1:0]  launched, fin, launched_nxt, fin_nxt;
    logic [NUM_ROW-1:0]  wb, wb_nxt;
    logic [TIMEOUT_W-1:0] wdog, wdog_nxt;
    logic                last;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign desc_ready = !fifo_full && (state != S_ERR);
    assign push       = desc_valid && desc_ready;

    assign col_valid   = (state == S_LAUNCH) ? ~launched : '0;
    assign core_busy   = (state != S_IDLE);
    assign core_finish = (state == S_DONE);
    assign core_error  = (state == S_ERR);

    // A finish pulse only counts once its column has accepted the launch.
    assign launched_nxt = launched | (col_valid & col_ready);
    assign fin_nxt      = fin | (col_finish & launched);
    assign wb_nxt       = wb | wb_finish;
    assign wdog_nxt     = wdog + TIMEOUT_W'(1);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {desc_w_num, desc_h_num, desc_c_num,
                                    desc_bit_mode, desc_kernel_mode, desc_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            launched     <= '0;
            fin          <= '0;
            wb           <= '0;
            wdog         <= '0;
            last         <= 1'b0;
            w_num        <= '0;
            h_num        <= '0;
            c_num        <= '0;
            bit_mode     <= 1'b0;
            kernel_mode  <= 1'b0;
            layer_cnt    <= '0;
            fm_ping_pong <= 1'b0;
        end else if (abort) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            launched <= '0;
            fin      <= '0;
            wb       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            unique case (state)
                S_IDLE: begin
                    if (core_start && !fifo_empty) begin
                        state     <= S_FETCH;
                        layer_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    {w_num, h_num, c_num, bit_mode, kernel_mode, last} <= mem[rd_ptr[AW-1:0]];
                    rd_ptr   <= rd_ptr + (AW+1)'(1);
                    launched <= '0;
                    fin      <= '0;
                    wb       <= '0;
                    wdog     <= '0;
                    state    <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    launched <= launched_nxt;
                    fin      <= fin_nxt;
                    wb       <= wb_nxt;
                    if (&launched_nxt)
                        state <= S_RUN;
                end
                S_RUN: begin
                    fin  <= fin_nxt;
                    wb   <= wb_nxt;
                    wdog <= wdog_nxt;
                    if ((&fin_nxt) && (&wb_nxt))
                        state <= S_SWAP;
                    else if (&wdog_nxt)
                        state <= S_ERR;
                end
                S_SWAP: begin
                    fm_ping_pong <= ~fm_ping_pong;
                    if (layer_cnt != 8'hff)
                        layer_cnt <= layer_cnt + 8'd1;
                    if (last)
                        state <= S_DONE;
                    else if (!fifo_empty)
                        state <= S_FETCH;
                    else
                        state <= S_WAIT;
                end
                // A push landing this cycle is readable by FETCH next cycle.
                S_WAIT: begin
                    if (!fifo_empty || push)
                        state <= S_FETCH;
                end
                S_DONE: state <= S_IDLE;
                S_ERR:  state <= S_ERR;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_diff_layer_seq.sv
// Directed and randomized bench for diff_layer_seq, checked against a descriptor-queue
// model that tracks bank select, layer count and per-layer launch/finish sets.
module tb_diff_layer_seq;
    localparam int NUM_COL    = 8;
    localparam int NUM_ROW    = 4;
    localparam int DESC_DEPTH = 4;
    localparam int DIM_W      = 8;
    localparam int TIMEOUT_W  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               desc_valid, desc_ready;
    logic [DIM_W-1:0]   desc_w_num, desc_h_num, desc_c_num;
    logic               desc_bit_mode, desc_kernel_mode, desc_last;
    logic               core_start, abort;
    logic               core_busy, core_finish, core_error;
    logic [7:0]         layer_cnt;
    logic [NUM_COL-1:0] col_valid, col_ready, col_finish;
    logic [NUM_ROW-1:0] wb_finish;
    logic [DIM_W-1:0]   w_num, h_num, c_num;
    logic               bit_mode, kernel_mode, fm_ping_pong;

    always #5 clk = ~clk;

    diff_layer_seq #(
        .NUM_COL(NUM_COL), .NUM_ROW(NUM_ROW), .DESC_DEPTH(DESC_DEPTH),
        .DIM_W(DIM_W), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_w_num(desc_w_num), .desc_h_num(desc_h_num), .desc_c_num(desc_c_num),
        .desc_bit_mode(desc_bit_mode), .desc_kernel_mode(desc_kernel_mode),
        .desc_last(desc_last), .core_start(core_start), .abort(abort),
        .core_busy(core_busy), .core_finish(core_finish), .core_error(core_error),
        .layer_cnt(layer_cnt), .col_valid(col_valid), .col_ready(col_ready),
        .col_finish(col_finish), .wb_finish(wb_finish),
        .w_num(w_num), .h_num(h_num), .c_num(c_num),
        .bit_mode(bit_mode), .kernel_mode(kernel_mode), .fm_ping_pong(fm_ping_pong)
    );

    typedef struct {
        logic [DIM_W-1:0] w, h, c;
        logic bm, km, last;
    } desc_t;

    desc_t      model_q[$];
    logic       pp_exp = 1'b0;
    logic [7:0] cnt_exp = 8'd0;
    int         n_assert = 0, n_fail = 0, n_finish = 0;
    desc_t      pend;
    bit         pend_on = 1'b0;

    always @(posedge clk) if (core_finish === 1'b1) n_finish++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic desc_t rand_desc(input logic last);
        desc_t d;
        d.w    = DIM_W'($urandom_range(1, 255));
        d.h    = DIM_W'($urandom_range(1, 255));
        d.c    = DIM_W'($urandom_range(1, 255));
        d.bm   = 1'($urandom_range(0, 1));
        d.km   = 1'($urandom_range(0, 1));
        d.last = last;
        return d;
    endfunction

    task automatic drive_desc(input desc_t d);
        desc_w_num       = d.w;
        desc_h_num       = d.h;
        desc_c_num       = d.c;
        desc_bit_mode    = d.bm;
        desc_kernel_mode = d.km;
        desc_last        = d.last;
    endtask

    task automatic push(input desc_t d);
        int t = 0;
        while (desc_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        chk("push_ready", desc_ready, 1);
        drive_desc(d);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        model_q.push_back(d);
    endtask

    task automatic start();
        core_start = 1'b1;
        step();
        core_start = 1'b0;
        if (model_q.size() != 0) cnt_exp = 8'd0;
    endtask

    // Entered in the FETCH cycle; returns in the cycle after SWAP (or in ERR for mode 4).
    // mode 0 random, 1 staggered ready, 2 stray/late col 0, 3 immediate, 4 withhold wb[0]
    task automatic run_layer(input int mode);
        desc_t d;
        logic [NUM_COL-1:0] launched = '0, fin = '0, cf, exp_v, one = 1;
        logic [NUM_ROW-1:0] wb = '0, wf, wone = 1;
        int dly[NUM_COL];
        int k, r, lim;

        chk("fetch_busy", core_busy, 1);
        chk("fetch_col_valid", col_valid, 0);
        for (int j = 0; j < NUM_COL; j++)
            dly[j] = (mode == 1) ? j : (mode == 2 && j == 0) ? 3 :
                     (mode == 3) ? 0 : $urandom_range(0, 3);
        step();
        chk("model_has_desc", model_q.size() != 0, 1);
        if (model_q.size() == 0) return;
        d = model_q.pop_front();
        chk("cfg_w", w_num, d.w);
        chk("cfg_h", h_num, d.h);
        chk("cfg_c", c_num, d.c);
        chk("cfg_bit_mode", bit_mode, d.bm);
        chk("cfg_kernel_mode", kernel_mode, d.km);

        k = 0;
        while (launched != {NUM_COL{1'b1}} && k < 40) begin
            exp_v = ~launched;
            chk("launch_col_valid", col_valid, exp_v);
            chk("launch_no_finish", core_finish, 0);
            for (int j = 0; j < NUM_COL; j++) col_ready[j] = (k >= dly[j]);
            col_finish = (mode == 2 && k == 0) ? one : '0;
            if (pend_on) begin
                if (k == 0) chk("ready_after_fetch", desc_ready, 1);
                drive_desc(pend);
                desc_valid = desc_ready;
                if (desc_ready === 1'b1) begin
                    model_q.push_back(pend);
                    pend_on = 1'b0;
                end
            end
            step();
            desc_valid = 1'b0;
            launched = launched | col_ready;
            k++;
        end
        chk("launch_done", &launched, 1);
        col_ready  = '0;
        col_finish = '0;

        lim = (mode == 4) ? 15 : 12;
        r = 0;
        while (!((&fin) && (&wb)) && r < lim) begin
            chk("run_col_valid", col_valid, 0);
            chk("run_pp_hold", fm_ping_pong, pp_exp);
            chk("run_busy", core_busy, 1);
            if (mode == 4) chk("run_no_error", core_error, 0);
            case (mode)
                2: begin
                    cf = (r == 0) ? ~one : ((r == 6) ? one : '0);
                    wf = (r == 0) ? '1 : '0;
                end
                3: begin
                    cf = (r == 0) ? '1 : '0;
                    wf = (r == 0) ? '1 : '0;
                end
                4: begin
                    cf = (r == 0) ? '1 : '0;
                    wf = (r == 0) ? ~wone : '0;
                end
                default: begin
                    cf = NUM_COL'($urandom);
                    wf = NUM_ROW'($urandom);
                    if (r >= 4) begin
                        cf = '1;
                        wf = '1;
                    end
                end
            endcase
            col_finish = cf;
            wb_finish  = wf;
            step();
            fin = fin | cf;
            wb  = wb | wf;
            col_finish = '0;
            wb_finish  = '0;
            r++;
        end

        if (mode == 4) begin
            chk("wdog_error", core_error, 1);
            chk("wdog_col_valid", col_valid, 0);
            chk("wdog_desc_ready", desc_ready, 0);
            return;
        end
        chk("run_all_finished", (&fin) && (&wb), 1);
        chk("swap_pp_hold", fm_ping_pong, pp_exp);
        chk("swap_col_valid", col_valid, 0);
        chk("cfg_hold_c", c_num, d.c);
        step();
        pp_exp = ~pp_exp;
        if (cnt_exp != 8'hff) cnt_exp = cnt_exp + 8'd1;
        chk("pp_toggle", fm_ping_pong, pp_exp);
        chk("layer_cnt", layer_cnt, cnt_exp);
        chk("finish_pulse", core_finish, d.last);
    endtask

    task automatic expect_idle();
        step();
        chk("idle_busy", core_busy, 0);
        chk("idle_finish", core_finish, 0);
    endtask

    initial begin
        desc_t d;
        int base, nl;

        rst = 1'b1;
        desc_valid = 1'b0; core_start = 1'b0; abort = 1'b0;
        col_ready = '0; col_finish = '0; wb_finish = '0;
        drive_desc(rand_desc(1'b0));
        step();
        step();
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_busy", core_busy, 0);
        chk("rst_finish", core_finish, 0);
        chk("rst_error", core_error, 0);
        chk("rst_col_valid", col_valid, 0);
        chk("rst_pp", fm_ping_pong, 0);
        chk("rst_layer_cnt", layer_cnt, 0);
        chk("rst_w_num", w_num, 0);
        rst = 1'b0;
        step();

        start();
        chk("empty_start_ignored", core_busy, 0);

        // single layer
        base = n_finish;
        d.w = 8'd16; d.h = 8'd16; d.c = 8'd3; d.bm = 1'b1; d.km = 1'b0; d.last = 1'b1;
        push(d);
        start();
        run_layer(3);
        expect_idle();
        chk("single_finish_count", n_finish - base, 1);

        // three layers, staggered column readiness
        base = n_finish;
        for (int i = 0; i < 3; i++) push(rand_desc(i == 2));
        start();
        for (int i = 0; i < 3; i++) run_layer(1);
        expect_idle();
        chk("three_finish_count", n_finish - base, 1);

        // FIFO full: extra push is lost and re-offered after the first pop
        for (int i = 0; i < DESC_DEPTH; i++) push(rand_desc(1'b0));
        chk("full_desc_ready", desc_ready, 0);
        pend = rand_desc(1'b1);
        drive_desc(pend);
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        pend_on = 1'b1;
        start();
        chk("full_ready_in_fetch", desc_ready, 0);
        for (int i = 0; i < DESC_DEPTH + 1; i++) run_layer(0);
        chk("reoffer_accepted", pend_on, 0);
        expect_idle();

        // starvation between layers
        push(rand_desc(1'b0));
        start();
        run_layer(0);
        for (int i = 0; i < 10; i++) begin
            chk("wait_busy", core_busy, 1);
            chk("wait_col_valid", col_valid, 0);
            step();
        end
        push(rand_desc(1'b1));
        run_layer(0);
        expect_idle();

        // stray finish from an unlaunched column
        push(rand_desc(1'b1));
        start();
        run_layer(2);
        expect_idle();

        // random networks
        for (int n = 0; n < 4; n++) begin
            base = n_finish;
            nl = $urandom_range(1, 3);
            for (int i = 0; i < nl; i++) push(rand_desc(i == nl - 1));
            start();
            for (int i = 0; i < nl; i++) run_layer(0);
            expect_idle();
            chk("rand_finish_count", n_finish - base, 1);
        end

        // watchdog then abort
        base = n_finish;
        push(rand_desc(1'b0));
        push(rand_desc(1'b1));
        start();
        run_layer(4);
        drive_desc(rand_desc(1'b1));
        desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        chk("err_sticky", core_error, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        model_q.delete();
        chk("abort_error_clear", core_error, 0);
        chk("abort_busy", core_busy, 0);
        chk("abort_pp_kept", fm_ping_pong, pp_exp);
        chk("abort_cnt_kept", layer_cnt, cnt_exp);
        chk("abort_desc_ready", desc_ready, 1);
        start();
        chk("abort_fifo_empty", core_busy, 0);
        step();
        chk("abort_no_finish", n_finish - base, 0);

        // asynchronous reset mid-layer
        push(rand_desc(1'b1));
        start();
        step();
        #2 rst = 1'b1;
        #1;
        chk("mrst_busy", core_busy, 0);
        chk("mrst_col_valid", col_valid, 0);
        chk("mrst_pp", fm_ping_pong, 0);
        chk("mrst_layer_cnt", layer_cnt, 0);
        chk("mrst_desc_ready", desc_ready, 1);
        step();
        rst = 1'b0;
        model_q.delete();
        pp_exp = 1'b0;
        cnt_exp = 8'd0;
        step();
        chk("mrst_idle", core_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/diff_layer_seq.md
# diff_layer_seq

Parametrised multi-layer sequencer for the diff core. It accepts a queue of layer descriptors and launches every PE column for each layer. It waits for all columns to finish computing and all rows to finish write-back, then flips the feature-map/guard ping-pong select and moves to the next layer, so a whole network runs from one start pulse. It sits between the host-side loader and the PE matrix, in place of the single-layer start/finish handshake.

## Interface
- NUM_COL, 8, PE columns driven (≥1)
- NUM_ROW, 4, PE rows reporting write-back (≥1)
- DESC_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- DIM_W, 8, width of w/h/c dimension fields
- TIMEOUT_W, 16, RUN-state watchdog counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- desc_valid  in  1  descriptor offered
- desc_ready  out  1  FIFO not full
- desc_w_num / desc_h_num / desc_c_num  in  DIM_W each  layer dimensions
- desc_bit_mode  in  1  bit mode of the layer
- desc_kernel_mode  in  1  kernel mode of the layer
- desc_last  in  1  last layer of the network
- core_start  in  1  start pulse
- abort  in  1  synchronous flush
- core_busy  out  1  state ≠ IDLE
- core_finish  out  1  one-cycle pulse after the last layer
- core_error  out  1  sticky watchdog error
- layer_cnt  out  8  layers completed since start
- col_valid  out  NUM_COL  per-column launch
- col_ready  in  NUM_COL  per-column accept
- col_finish  in  NUM_COL  per-column compute-done pulse
- wb_finish  in  NUM_ROW  per-row write-back-done pulse
- w_num / h_num / c_num  out  DIM_W each  current layer config
- bit_mode, kernel_mode  out  1 each  current layer config, broadcast to all columns
- fm_ping_pong  out  1  buffer bank select

## Operation
**Descriptor FIFO**
- Push when desc_valid && desc_ready.
- desc_ready = !full, taken from registered state; there is no bypass.
- If a push and a pop happen in the same cycle while the FIFO is full, the pop succeeds and the push is refused.
- Pushes are allowed in every state except ERR.

**States:** IDLE, FETCH, LAUNCH, RUN, SWAP, WAIT, DONE, ERR.
- IDLE
  - core_start with the FIFO non-empty → FETCH, and layer_cnt clears to 0.
  - core_start with the FIFO empty is ignored.
- FETCH: pop the head into the config registers (w/h/c_num, bit_mode, kernel_mode, last) → LAUNCH. Clears the launch mask, the finish mask and the watchdog.
- LAUNCH
  - col_valid[j] = !launched[j].
  - A handshake (valid && ready) sets launched[j]; that column's valid drops the next cycle.
  - When all columns are launched → RUN.
- Finish capture (LAUNCH and RUN)
  - col_finish[j] sets fin[j] only if launched[j] is already set. A pulse from an unlaunched column is ignored.
  - wb_finish[i] sets wb[i].
- RUN
  - The watchdog increments every cycle.
  - When fin and wb are all ones → SWAP.
  - If the watchdog reaches all-ones → ERR.
- SWAP: toggle fm_ping_pong and increment layer_cnt (saturates at 255). Then:
  - → DONE if last is set;
  - → FETCH if the FIFO is non-empty;
  - → WAIT otherwise.
- WAIT → FETCH as soon as the FIFO is non-empty.
- DONE: core_finish = 1 for this cycle → IDLE.
- ERR
  - core_error is set; col_valid is 0; FIFO pushes are refused (desc_ready = 0).
  - Leaves only via abort or rst.
- abort (any state, highest priority)
  - Flushes the FIFO, clears the masks → IDLE. No core_finish pulse.
  - Clears core_error.
  - Keeps fm_ping_pong and layer_cnt.
- Config outputs hold their values from FETCH until the next FETCH.

## Timing
- Reset values:
  - desc_ready = 1; every other output = 0, including fm_ping_pong and layer_cnt.
  - FIFO empty; state IDLE.
- All outputs are registered or decoded from registered state. No combinational path from col_ready, col_finish or wb_finish to any output.
- core_start sampled in cycle N: FETCH in N+1, col_valid high in N+2.
- Last required finish sampled in RUN in cycle N: SWAP in N+1 (fm_ping_pong toggles at the end of N+1).
  - Next layer: FETCH in N+2, col_valid high in N+3.
  - Final layer: core_finish high in N+2.
- A column handshaking in its first LAUNCH cycle leaves LAUNCH after that cycle, so the minimum LAUNCH time is 1 cycle.
- rst mid-operation returns all state to its reset values immediately.

## Test plan
- Single layer:
  - Stimulus: push one descriptor (w=16, h=16, c=3, last=1); all col_ready tied 1; pulse core_start; one cycle after launch pulse all col_finish and wb_finish.
  - Response: col_valid all-ones for exactly 1 cycle, 2 cycles after start; fm_ping_pong = 1; layer_cnt = 1; core_finish pulses 2 cycles after the finish sample.
- Three layers with staggered readiness:
  - Stimulus: column j's ready rises j cycles late; push 3 descriptors (last on the third).
  - Response: each col_valid[j] drops the cycle after its own handshake; fm_ping_pong follows 1, 0, 1; layer_cnt = 3; exactly one core_finish.
- FIFO full:
  - Stimulus: push DESC_DEPTH descriptors while IDLE.
  - Response: desc_ready = 0. On start, desc_ready returns to 1 the cycle after FETCH. A push attempted while full is lost, so the bench must re-offer it.
- Starvation:
  - Stimulus: a non-last layer finishes with the FIFO empty; push the next descriptor 10 cycles later.
  - Response: the block sits in WAIT with core_busy = 1 and col_valid = 0; FETCH happens the cycle after the push.
- Watchdog:
  - Stimulus: TIMEOUT_W = 4; withhold wb_finish[0].
  - Response: core_error = 1 after 15 RUN cycles; col_valid = 0; desc_ready = 0.
  - Then abort: error clears, the FIFO empties, and no core_finish pulse occurs.
- Early and stray finish:
  - Stimulus: col_finish[0] pulses before column 0 is launched.
  - Response: the pulse is ignored; RUN does not exit until a new col_finish[0] arrives after launch.
